// File: rtl/mmio_bus_arbiter_pkg.sv
// Shared definitions for the two-requester MMIO bus arbiter: FSM encoding,
// requester IDs and the decoder's region codes.
package mmio_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_ACK  = 2'b10
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Region field seen by the address decoder (byte address bits [3:2]).
  localparam logic [1:0] REGION_MEM0  = 2'b00;
  localparam logic [1:0] REGION_MEM1  = 2'b01;
  localparam logic [1:0] REGION_ACCEL = 2'b10;
  localparam logic [1:0] REGION_GPIO  = 2'b11;

endpackage

// File: rtl/mmio_bus_arbiter_select.sv
// Combinational two-way winner pick: round-robin against the last-served
// requester, or requester 0 always first when FIXED_PRI is nonzero.
module arb_rr_select
  import mmio_bus_arbiter_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_served,
  output logic winner,
  output logic valid
);

  always_comb begin
    valid  = req0 | req1;
    winner = REQ_CPU;
    if (req0 && req1) begin
      winner = (FIXED_PRI != 0) ? REQ_CPU : ~last_served;
    end else if (req1) begin
      winner = REQ_DBG;
    end
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Serializes CPU and debug-loader transactions onto the single MMIO bus.
// Every transaction walks IDLE -> XFER -> ACK; all bus outputs are registered.
module mmio_bus_arbiter
  import mmio_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_we_q, bus_we_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;

  logic winner;
  logic win_valid;

  arb_rr_select #(
    .FIXED_PRI(FIXED_PRI)
  ) u_select (
    .req0       (req0),
    .req1       (req1),
    .last_served(last_q),
    .winner     (winner),
    .valid      (win_valid)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    bus_we_d    = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          owner_d     = winner;
          bus_addr_d  = (winner == REQ_DBG) ? addr1 : addr0;
          bus_we_d    = (winner == REQ_DBG) ? we1 : we0;
          bus_wdata_d = (winner == REQ_DBG) ? wdata1 : wdata0;
          state_d     = ST_XFER;
        end
      end
      ST_XFER: begin
        // Writes capture the mux output too; requesters ignore it then.
        rdata_d = bus_rdata;
        ack0_d  = (owner_q == REQ_CPU);
        ack1_d  = (owner_q == REQ_DBG);
        state_d = ST_ACK;
      end
      ST_ACK: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= REQ_CPU;
      last_q      <= REQ_DBG;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign bus_addr  = bus_addr_q;
  assign bus_we    = bus_we_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter: a round-robin instance checked through an ack
// scoreboard plus inline bus checks, and a fixed-priority instance.
module tb_mmio_bus_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SB_W = 1 + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          ack0, ack1, busy, bus_we;
  logic [DW-1:0] rdata, bus_wdata, bus_rdata;
  logic [AW-1:0] bus_addr;

  logic          fp_ack0, fp_ack1, fp_busy, fp_bus_we;
  logic [DW-1:0] fp_rdata, fp_bus_wdata, fp_bus_rdata;
  logic [AW-1:0] fp_bus_addr;

  logic [SB_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Read-mux model: a tag plus the word index of the decoded address.
  assign bus_rdata    = 32'hA5A5_0000 | {16'h0, bus_addr[17:2]};
  assign fp_bus_rdata = 32'hA5A5_0000 | {16'h0, fp_bus_addr[17:2]};

  mmio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  mmio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(fp_ack0), .ack1(fp_ack1), .rdata(fp_rdata), .busy(fp_busy),
    .bus_addr(fp_bus_addr), .bus_we(fp_bus_we), .bus_wdata(fp_bus_wdata),
    .bus_rdata(fp_bus_rdata)
  );

  // Scoreboard: every ack on the round-robin instance pops one {id, rdata}.
  always @(negedge clk) begin
    logic [SB_W-1:0] got, exp;
    if (ack0 || ack1) begin
      n_vec++;
      if (ack0 && ack1) begin
        n_err++;
        $display("FAIL ack_onehot: ack0=1 ack1=1, required at most one");
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL ack_unexpected: ack%0d rdata=%h, required no ack", ack1, rdata);
      end else begin
        got = {ack1, rdata};
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL ack_data: got id=%0d rdata=%h, required id=%0d rdata=%h",
                   got[DW], got[DW-1:0], exp[DW], exp[DW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    req0 = 1; req1 = 1; we0 = 1; addr0 = 32'h0C; wdata0 = 32'h1234_5678;
    repeat (3) tick();
    n_vec++;
    if ({ack0, ack1, bus_we, busy} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: ack0/ack1/bus_we/busy=%b, required 0000",
               {ack0, ack1, bus_we, busy});
    end
    n_vec++;
    if ({bus_addr, bus_wdata, rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data: bus_addr=%h bus_wdata=%h rdata=%h, required all 0",
               bus_addr, bus_wdata, rdata);
    end
    clear_inputs();
    rst = 0;
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_single_read();
    addr0 = 32'h0000_000C; we0 = 0; req0 = 1;
    exp_q.push_back({1'b0, 32'hA5A5_0003});
    tick();
    n_vec++;
    if ({bus_addr, bus_we, busy, ack0} !== {32'h0C, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL read_xfer: bus_addr=%h bus_we=%b busy=%b ack0=%b, required 0000000c 0 1 0",
               bus_addr, bus_we, busy, ack0);
    end
    tick();
    n_vec++;
    if ({ack0, ack1, rdata} !== {1'b1, 1'b0, 32'hA5A5_0003}) begin
      n_err++;
      $display("FAIL read_ack: ack0=%b ack1=%b rdata=%h, required 1 0 a5a50003", ack0, ack1, rdata);
    end
    req0 = 0;
    tick();
    n_vec++;
    if ({busy, ack0} !== 2'b00) begin
      n_err++;
      $display("FAIL read_done: busy=%b ack0=%b, required 0 0", busy, ack0);
    end
  endtask

  task automatic test_single_write();
    addr1 = 32'h08; wdata1 = 32'h0000_0005; we1 = 1; req1 = 1;
    exp_q.push_back({1'b1, 32'hA5A5_0002});
    tick();
    n_vec++;
    if ({bus_we, bus_wdata, bus_addr} !== {1'b1, 32'h5, 32'h8}) begin
      n_err++;
      $display("FAIL write_xfer: bus_we=%b bus_wdata=%h bus_addr=%h, required 1 00000005 00000008",
               bus_we, bus_wdata, bus_addr);
    end
    tick();
    n_vec++;
    if ({bus_we, ack1, ack0} !== 3'b010) begin
      n_err++;
      $display("FAIL write_ack: bus_we=%b ack1=%b ack0=%b, required 0 1 0", bus_we, ack1, ack0);
    end
    req1 = 0; we1 = 0;
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL write_done: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    addr0 = 32'h10; addr1 = 32'h20;
    for (int k = 0; k < 4; k++)
      exp_q.push_back((k % 2 == 0) ? {1'b0, 32'hA5A5_0004} : {1'b1, 32'hA5A5_0008});
    req0 = 1; req1 = 1;
    for (int i = 1; i <= 11; i++) begin
      logic exp_ack;
      tick();
      exp_ack = (i % 3 == 2);
      n_vec++;
      if ((ack0 | ack1) !== exp_ack) begin
        n_err++;
        $display("FAIL rr_cadence: cycle %0d ack=%b, required %b", i, ack0 | ack1, exp_ack);
      end
    end
    req0 = 0; req1 = 0;
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL rr_done: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_fixed_pri();
    int cnt0 = 0;
    int cnt1 = 0;
    apply_reset();
    addr0 = 32'h10; addr1 = 32'h20;
    exp_q.push_back({1'b0, 32'hA5A5_0004});
    exp_q.push_back({1'b1, 32'hA5A5_0008});
    exp_q.push_back({1'b0, 32'hA5A5_0004});
    req0 = 1; req1 = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (fp_ack0) begin
        cnt0++;
        n_vec++;
        if (fp_rdata !== 32'hA5A5_0004) begin
          n_err++;
          $display("FAIL fp_rdata: rdata=%h, required a5a50004", fp_rdata);
        end
      end
      if (fp_ack1) cnt1++;
    end
    req0 = 0; req1 = 0;
    tick();
    n_vec++;
    if (cnt0 != 3 || cnt1 != 0) begin
      n_err++;
      $display("FAIL fp_order: ack0 count=%0d ack1 count=%0d, required 3 0", cnt0, cnt1);
    end
    n_vec++;
    if (fp_busy !== 1'b0) begin
      n_err++;
      $display("FAIL fp_done: busy=%b, required 0", fp_busy);
    end
  endtask

  task automatic test_late_drop();
    addr0 = 32'h14; we0 = 0; req0 = 1;
    exp_q.push_back({1'b0, 32'hA5A5_0005});
    tick();
    req0 = 0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL drop_busy: busy=%b, required 1", busy);
    end
    tick();
    n_vec++;
    if (ack0 !== 1'b1) begin
      n_err++;
      $display("FAIL drop_ack: ack0=%b, required 1", ack0);
    end
    tick();
    n_vec++;
    if ({busy, ack0} !== 2'b00) begin
      n_err++;
      $display("FAIL drop_idle: busy=%b ack0=%b, required 0 0", busy, ack0);
    end
  endtask

  task automatic test_reset_in_xfer();
    addr0 = 32'h04; wdata0 = 32'hDEAD_BEEF; we0 = 1; req0 = 1;
    tick();
    n_vec++;
    if (bus_we !== 1'b1) begin
      n_err++;
      $display("FAIL rstx_we: bus_we=%b, required 1", bus_we);
    end
    rst = 1; req0 = 0; we0 = 0;
    tick();
    n_vec++;
    if ({bus_we, ack0, busy, rdata} !== {3'b000, 32'h0}) begin
      n_err++;
      $display("FAIL rstx_abort: bus_we=%b ack0=%b busy=%b rdata=%h, required 0 0 0 00000000",
               bus_we, ack0, busy, rdata);
    end
    rst = 0;
    tick();
    n_vec++;
    if ({ack0, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL rstx_noack: ack0=%b busy=%b, required 0 0", ack0, busy);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_fixed_pri();
    test_late_drop();
    test_reset_in_xfer();
    repeat (2) tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d acks outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
